// File: rtl/fcta_stage_scheduler_if.sv
// Stage-sequencer control bundle: run requests in, stage/layer/sample walk out.
// Signal prefixes are from the scheduler's point of view (i_ = into scheduler).
interface fcta_stage_scheduler_if #(
  parameter int LAYER_BW = 2,
  parameter int BATCH_BW = 3
);
  logic                i_start;
  logic                i_train_en;
  logic                i_abort;
  logic                i_stage_done;
  logic [2:0]          o_stage;
  logic [LAYER_BW-1:0] o_layer_idx;
  logic [BATCH_BW-1:0] o_sample_cnt;
  logic                o_stage_go;
  logic                o_busy;
  logic                o_run_done;

  modport slave (
    input  i_start, i_train_en, i_abort, i_stage_done,
    output o_stage, o_layer_idx, o_sample_cnt, o_stage_go, o_busy, o_run_done
  );

  modport master (
    output i_start, i_train_en, i_abort, i_stage_done,
    input  o_stage, o_layer_idx, o_sample_cnt, o_stage_go, o_busy, o_run_done
  );
endinterface

// File: rtl/fcta_stage_scheduler.sv
// Training/inference sequencer: walks the shared stage datapath per layer and
// per sample, then issues the parameter update once per batch.
//
// state   | meaning
// IDLE    | waiting for start
// A0      | load input activation of the current sample
// FP      | forward pass, layer_idx ascending
// SOFTMAX | output softmax / loss, layer_idx = last layer
// BPDZ    | backprop dZ for layer_idx (descending)
// BPDA    | backprop dA into layer_idx-1 (never for layer 0)
// BPDW    | backprop dW for layer_idx
// PU      | parameter update, layer_idx ascending, once per batch
module fcta_stage_scheduler #(
  parameter int N_LAYERS = 3,
  parameter int LAYER_BW = 2,
  parameter int BATCH    = 8,
  parameter int BATCH_BW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  fcta_stage_scheduler_if.slave sif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_A0      = 3'd1,
    ST_FP      = 3'd2,
    ST_SOFTMAX = 3'd3,
    ST_BPDZ    = 3'd4,
    ST_BPDA    = 3'd5,
    ST_BPDW    = 3'd6,
    ST_PU      = 3'd7
  } stage_t;

  localparam logic [LAYER_BW-1:0] LAST_LAYER  = LAYER_BW'(N_LAYERS - 1);
  localparam logic [BATCH_BW-1:0] LAST_SAMPLE = BATCH_BW'(BATCH - 1);

  stage_t              r_stage;
  logic [LAYER_BW-1:0] r_layer;
  logic [BATCH_BW-1:0] r_sample;
  logic                r_go;
  logic                r_busy;
  logic                r_run_done;
  logic                r_train;
  logic                w_honor;

  // Done is ignored in the go cycle so every stage lasts at least two cycles.
  assign w_honor = sif.i_stage_done && (r_stage != ST_IDLE) && !r_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage    <= ST_IDLE;
      r_layer    <= '0;
      r_sample   <= '0;
      r_go       <= 1'b0;
      r_busy     <= 1'b0;
      r_run_done <= 1'b0;
      r_train    <= 1'b0;
    end else begin
      r_go       <= 1'b0;
      r_run_done <= 1'b0;
      if (sif.i_abort) begin
        r_stage  <= ST_IDLE;
        r_layer  <= '0;
        r_sample <= '0;
        r_busy   <= 1'b0;
        r_train  <= 1'b0;
      end else if (r_stage == ST_IDLE) begin
        if (sif.i_start) begin
          r_train  <= sif.i_train_en;
          r_sample <= '0;
          r_layer  <= '0;
          r_stage  <= ST_A0;
          r_go     <= 1'b1;
          r_busy   <= 1'b1;
        end
      end else if (w_honor) begin
        r_go <= 1'b1;
        unique case (r_stage)
          ST_A0: begin
            r_stage <= ST_FP;
            r_layer <= '0;
          end
          ST_FP: begin
            if (r_layer == LAST_LAYER) r_stage <= ST_SOFTMAX;
            else                       r_layer <= r_layer + 1'b1;
          end
          ST_SOFTMAX: begin
            if (r_train) begin
              r_stage <= ST_BPDZ;
              r_layer <= LAST_LAYER;
            end else begin
              r_stage    <= ST_IDLE;
              r_layer    <= '0;
              r_go       <= 1'b0;
              r_busy     <= 1'b0;
              r_run_done <= 1'b1;
            end
          end
          ST_BPDZ: r_stage <= ST_BPDW;
          ST_BPDW: begin
            if (r_layer != '0) begin
              r_stage <= ST_BPDA;
            end else if (r_sample == LAST_SAMPLE) begin
              r_stage <= ST_PU;
              r_layer <= '0;
            end else begin
              r_sample <= r_sample + 1'b1;
              r_stage  <= ST_A0;
              r_layer  <= '0;
            end
          end
          ST_BPDA: begin
            r_stage <= ST_BPDZ;
            r_layer <= r_layer - 1'b1;
          end
          ST_PU: begin
            if (r_layer == LAST_LAYER) begin
              r_stage    <= ST_IDLE;
              r_layer    <= '0;
              r_sample   <= '0;
              r_go       <= 1'b0;
              r_busy     <= 1'b0;
              r_run_done <= 1'b1;
            end else begin
              r_layer <= r_layer + 1'b1;
            end
          end
          default: r_go <= 1'b0;
        endcase
      end
    end
  end

  assign sif.o_stage      = r_stage;
  assign sif.o_layer_idx  = r_layer;
  assign sif.o_sample_cnt = r_sample;
  assign sif.o_stage_go   = r_go;
  assign sif.o_busy       = r_busy;
  assign sif.o_run_done   = r_run_done;

endmodule

// File: tb/tb_fcta_stage_scheduler.sv
// Bench for fcta_stage_scheduler: two instances (3 layers/batch 2, 1 layer/batch 1)
// checked against a stage-list model built from the sequencing rules.
module tb_fcta_stage_scheduler;

  typedef struct {
    int stage;
    int layer;
    int sample;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic drv_start = 1'b0, drv_train = 1'b0, drv_abort = 1'b0, drv_done = 1'b0;
  logic sel = 1'b0;

  fcta_stage_scheduler_if #(.LAYER_BW(2), .BATCH_BW(3)) ifa ();
  fcta_stage_scheduler_if #(.LAYER_BW(1), .BATCH_BW(1)) ifb ();

  assign ifa.i_start      = drv_start & ~sel;
  assign ifa.i_train_en   = drv_train;
  assign ifa.i_abort      = drv_abort & ~sel;
  assign ifa.i_stage_done = drv_done & ~sel;
  assign ifb.i_start      = drv_start & sel;
  assign ifb.i_train_en   = drv_train;
  assign ifb.i_abort      = drv_abort & sel;
  assign ifb.i_stage_done = drv_done & sel;

  fcta_stage_scheduler #(.N_LAYERS(3), .LAYER_BW(2), .BATCH(2), .BATCH_BW(3))
    dut_a (.clk(clk), .rst(rst), .sif(ifa.slave));
  fcta_stage_scheduler #(.N_LAYERS(1), .LAYER_BW(1), .BATCH(1), .BATCH_BW(1))
    dut_b (.clk(clk), .rst(rst), .sif(ifb.slave));

  int   m_stage, m_layer, m_sample;
  logic m_go, m_busy, m_run_done;
  always_comb begin
    if (sel) begin
      m_stage = int'(ifb.o_stage);  m_layer = int'(ifb.o_layer_idx);
      m_sample = int'(ifb.o_sample_cnt);
      m_go = ifb.o_stage_go; m_busy = ifb.o_busy; m_run_done = ifb.o_run_done;
    end else begin
      m_stage = int'(ifa.o_stage);  m_layer = int'(ifa.o_layer_idx);
      m_sample = int'(ifa.o_sample_cnt);
      m_go = ifa.o_stage_go; m_busy = ifa.o_busy; m_run_done = ifa.o_run_done;
    end
  end

  int   tests_run = 0;
  int   tests_failed = 0;
  rec_t exp_q[$];
  rec_t got_q[$];
  int   rd_cnt, busy_cyc;
  bit   run_fin;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stage_go list, straight from the per-sample/per-batch stage rules.
  function automatic void build_exp(int nl, int nb, bit train);
    exp_q.delete();
    for (int s = 0; s < (train ? nb : 1); s++) begin
      exp_q.push_back(rec_t'{1, 0, s});
      for (int l = 0; l < nl; l++) exp_q.push_back(rec_t'{2, l, s});
      exp_q.push_back(rec_t'{3, nl - 1, s});
      if (train) begin
        for (int l = nl - 1; l >= 0; l--) begin
          exp_q.push_back(rec_t'{4, l, s});
          exp_q.push_back(rec_t'{6, l, s});
          if (l > 0) exp_q.push_back(rec_t'{5, l, s});
        end
      end
    end
    if (train) for (int l = 0; l < nl; l++) exp_q.push_back(rec_t'{7, l, nb - 1});
  endfunction

  // Starts a run and answers each stage_go with a done 1..1+max_extra cycles later.
  task automatic do_run(input bit train, input int max_extra, input bit poke);
    int pend = 0;
    got_q.delete(); rd_cnt = 0; busy_cyc = 0; run_fin = 0;
    drv_train = train; drv_start = 1'b1;
    step();
    drv_start = 1'b0;
    drv_train = 1'($urandom_range(1, 0));
    for (int c = 0; c < 3000 && !run_fin; c++) begin
      drv_done = 1'b0; drv_start = 1'b0;
      if (m_busy) busy_cyc++;
      if (m_run_done) begin rd_cnt++; run_fin = 1; end
      if (m_go) begin
        got_q.push_back(rec_t'{m_stage, m_layer, m_sample});
        pend = 1 + int'($urandom_range(max_extra, 0));
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) drv_done = 1'b1;
      end
      if (poke && m_busy && !run_fin && $urandom_range(3, 0) == 0) drv_start = 1'b1;
      if (!run_fin) step();
    end
    drv_done = 1'b0; drv_start = 1'b0;
    step();
    if (m_run_done) rd_cnt++;
  endtask

  task automatic drive_until(input int st, input int ly, output bit ok);
    bit pend = 0;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      drv_done = 1'b0;
      if (m_stage == st && m_layer == ly) begin ok = 1; return; end
      if (m_go) pend = 1;
      else if (pend) begin drv_done = 1'b1; pend = 0; end
      step();
    end
  endtask

  task automatic test_reset();
    bit ok;
    sel = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    tests_run++;
    if ({m_stage, m_layer, m_sample} !== {32'd0, 32'd0, 32'd0} || m_go !== 1'b0 ||
        m_busy !== 1'b0 || m_run_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: stage=%0d layer=%0d sample=%0d go=%b busy=%b rd=%b, want all 0",
               m_stage, m_layer, m_sample, m_go, m_busy, m_run_done);
    end
    drv_train = 1'b1; drv_start = 1'b1;
    step();
    drv_start = 1'b0;
    drive_until(2, 1, ok);
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL reach_fp1: stage=%0d layer=%0d, want FP layer 1", m_stage, m_layer);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (m_stage !== 0 || m_layer !== 0 || m_sample !== 0 || m_go !== 1'b0 ||
        m_busy !== 1'b0 || m_run_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: stage=%0d layer=%0d sample=%0d go=%b busy=%b rd=%b, want all 0",
               m_stage, m_layer, m_sample, m_go, m_busy, m_run_done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    tests_run++;
    if (m_stage !== 0 || m_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: stage=%0d busy=%b, want 0/0", m_stage, m_busy);
    end
  endtask

  task automatic test_inference();
    sel = 1'b0;
    build_exp(3, 2, 1'b0);
    do_run(1'b0, 0, 1'b0);
    tests_run++;
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL infer_len: got %0d go pulses, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] != exp_q[i]) begin
        tests_failed++;
        $display("FAIL infer_seq[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, got_q[i].stage,
                 got_q[i].layer, got_q[i].sample, exp_q[i].stage, exp_q[i].layer, exp_q[i].sample);
      end
    end
    tests_run++;
    if (busy_cyc !== 10 || rd_cnt !== 1 || run_fin !== 1'b1) begin
      tests_failed++;
      $display("FAIL infer_timing: busy=%0d run_done=%0d fin=%b, want 10/1/1", busy_cyc, rd_cnt, run_fin);
    end
  endtask

  task automatic test_training();
    for (int r = 0; r < 2; r++) begin
      sel = 1'b0;
      build_exp(3, 2, 1'b1);
      do_run(1'b1, 3, r[0]);
      tests_run++;
      if (got_q.size() !== 29 || exp_q.size() !== 29) begin
        tests_failed++;
        $display("FAIL train_len: got %0d go pulses, model %0d, want 29", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i] != exp_q[i]) begin
          tests_failed++;
          $display("FAIL train_seq[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, got_q[i].stage,
                   got_q[i].layer, got_q[i].sample, exp_q[i].stage, exp_q[i].layer, exp_q[i].sample);
        end
      end
      tests_run++;
      if (rd_cnt !== 1 || m_sample !== 0 || m_stage !== 0) begin
        tests_failed++;
        $display("FAIL train_end: run_done=%0d sample=%0d stage=%0d, want 1/0/0", rd_cnt, m_sample, m_stage);
      end
    end
  endtask

  task automatic test_done_ignore();
    sel = 1'b0;
    drv_done = 1'b1;
    repeat (3) step();
    drv_done = 1'b0;
    tests_run++;
    if (m_stage !== 0 || m_go !== 1'b0 || m_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_in_idle: stage=%0d go=%b busy=%b, want 0/0/0", m_stage, m_go, m_busy);
    end
    drv_train = 1'b0; drv_start = 1'b1;
    step();
    drv_start = 1'b0;
    tests_run++;
    if (m_stage !== 1 || m_go !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_go: stage=%0d go=%b, want 1/1", m_stage, m_go);
    end
    drv_done = 1'b1;
    step();
    tests_run++;
    if (m_stage !== 1 || m_go !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_in_go: stage=%0d go=%b, want 1/0", m_stage, m_go);
    end
    step();
    tests_run++;
    if (m_stage !== 2 || m_layer !== 0 || m_go !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_adv1: stage=%0d layer=%0d go=%b, want 2/0/1", m_stage, m_layer, m_go);
    end
    step();
    tests_run++;
    if (m_stage !== 2 || m_layer !== 0 || m_go !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_hold: stage=%0d layer=%0d go=%b, want 2/0/0", m_stage, m_layer, m_go);
    end
    step();
    drv_done = 1'b0;
    tests_run++;
    if (m_stage !== 2 || m_layer !== 1 || m_go !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_adv2: stage=%0d layer=%0d go=%b, want 2/1/1", m_stage, m_layer, m_go);
    end
    drv_abort = 1'b1;
    step();
    drv_abort = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    sel = 1'b0;
    drv_train = 1'b1; drv_start = 1'b1;
    step();
    drv_start = 1'b0;
    drive_until(6, 2, ok);
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL reach_bpdw2: stage=%0d layer=%0d, want BPdW layer 2", m_stage, m_layer);
    end
    step();
    drv_abort = 1'b1; drv_done = 1'b1;
    step();
    drv_abort = 1'b0; drv_done = 1'b0;
    tests_run++;
    if (m_stage !== 0 || m_layer !== 0 || m_sample !== 0 || m_go !== 1'b0 ||
        m_busy !== 1'b0 || m_run_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: stage=%0d layer=%0d sample=%0d go=%b busy=%b rd=%b, want all 0",
               m_stage, m_layer, m_sample, m_go, m_busy, m_run_done);
    end
    step();
    tests_run++;
    if (m_run_done !== 1'b0 || m_go !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_quiet: rd=%b go=%b, want 0/0", m_run_done, m_go);
    end
    drv_abort = 1'b1; drv_start = 1'b1;
    step();
    drv_abort = 1'b0; drv_start = 1'b0;
    tests_run++;
    if (m_stage !== 0 || m_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_over_start: stage=%0d busy=%b, want 0/0", m_stage, m_busy);
    end
    build_exp(3, 2, 1'b0);
    do_run(1'b0, 2, 1'b0);
    tests_run++;
    if (got_q.size() !== exp_q.size() || rd_cnt !== 1) begin
      tests_failed++;
      $display("FAIL restart_after_abort: got %0d pulses rd=%0d, want %0d/1", got_q.size(), rd_cnt, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] != exp_q[i]) begin
        tests_failed++;
        $display("FAIL restart_seq[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, got_q[i].stage,
                 got_q[i].layer, got_q[i].sample, exp_q[i].stage, exp_q[i].layer, exp_q[i].sample);
      end
    end
  endtask

  task automatic test_single_layer();
    sel = 1'b1;
    step();
    build_exp(1, 1, 1'b1);
    do_run(1'b1, 2, 1'b1);
    tests_run++;
    if (got_q.size() !== 6 || exp_q.size() !== 6 || rd_cnt !== 1) begin
      tests_failed++;
      $display("FAIL small_len: got %0d pulses model %0d rd=%0d, want 6/6/1", got_q.size(), exp_q.size(), rd_cnt);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] != exp_q[i]) begin
        tests_failed++;
        $display("FAIL small_seq[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, got_q[i].stage,
                 got_q[i].layer, got_q[i].sample, exp_q[i].stage, exp_q[i].layer, exp_q[i].sample);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inference();
    test_training();
    test_done_ignore();
    test_abort();
    test_single_layer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fcta_stage_scheduler.md
Name: fcta_stage_scheduler

Overview:
- Top-level training/inference sequencer for the FC training accelerator.
- Walks the shared stage datapath through the `stage_t` encoding (IDLE, A0, FP, SOFTMAX, BPdZ, BPdA, BPdW, PU) per layer and per sample, then issues the parameter update once per batch.
- Drives `stage`/`layer_idx` to the engines, pulses `stage_go` on entry to each stage, and waits for `stage_done` before advancing.

Parameters:
- N_LAYERS, 3, number of FC layers (>=1)
- LAYER_BW, 2, width of `layer_idx` (>= clog2(N_LAYERS), min 1)
- BATCH, 8, samples per parameter update (>=1)
- BATCH_BW, 3, width of `sample_cnt` (>= clog2(BATCH), min 1)

Ports:
- clk in 1 system clock, rising edge
- rst in 1 asynchronous active-high reset
- start in 1 run request; accepted only in IDLE
- train_en in 1 sampled with accepted start; 1 = training run, 0 = inference only
- abort in 1 synchronous abort, any state
- stage_done in 1 current stage engine finished (single-cycle pulse)
- stage out 3 current stage, `stage_t` encoding: IDLE=0, A0=1, FP=2, SOFTMAX=3, BPdZ=4, BPdA=5, BPdW=6, PU=7
- layer_idx out LAYER_BW layer addressed by current stage
- sample_cnt out BATCH_BW sample index within batch
- stage_go out 1 one-cycle pulse in the first cycle of each non-IDLE stage
- busy out 1 stage != IDLE
- run_done out 1 one-cycle pulse on normal completion

Behaviour:
- Reset and abort values: stage=IDLE, layer_idx=0, sample_cnt=0, stage_go=0, busy=0, run_done=0, latched train_en=0. Async reset takes effect immediately.
- All outputs are registered. `stage_go` is high in exactly the cycle `stage` first shows the new value.
- `stage_done` is honoured only when stage != IDLE and `stage_go`=0. It is ignored in the go cycle and in IDLE, so every stage lasts >=2 cycles.
- Transition rule: the cycle after an honoured `stage_done`, the next stage is entered with `stage_go`=1.
- IDLE + start: latch `train_en`; set sample_cnt=0, layer_idx=0; enter A0 next cycle. Start while busy is ignored.
- A0 done -> FP, layer 0.
- FP l done:
  - l < N_LAYERS-1 -> FP, l+1.
  - l = N_LAYERS-1 -> SOFTMAX, layer_idx held at N_LAYERS-1.
- SOFTMAX done:
  - train=0 -> IDLE, `run_done` pulse same cycle as IDLE entry.
  - train=1 -> BPdZ, layer N_LAYERS-1.
- BPdZ l done -> BPdW, l.
- BPdW l done:
  - l > 0 -> BPdA, l.
  - l = 0 -> end of sample; no BPdA for layer 0.
- BPdA l done -> BPdZ, l-1.
- End of sample:
  - sample_cnt < BATCH-1 -> sample_cnt+1, A0, layer 0.
  - sample_cnt = BATCH-1 -> PU, layer 0; sample_cnt held.
- PU l done:
  - l < N_LAYERS-1 -> PU, l+1.
  - l = N_LAYERS-1 -> IDLE, `run_done` pulse; sample_cnt cleared to 0.
- Inference runs exactly one sample; sample_cnt stays 0.
- abort: next cycle go to IDLE with reset values, no `run_done`. Abort has priority over `stage_done` and start in the same cycle.
- N_LAYERS=1: FP0 -> SOFTMAX -> BPdZ0 -> BPdW0 -> end of sample. BPdA is never entered.
- BATCH=1: PU follows the first sample.
- Counters never wrap. layer_idx stays in [0, N_LAYERS-1]; sample_cnt stays in [0, BATCH-1].
- Stage count per training run = BATCH*(2*N_LAYERS + 2 + 2*N_LAYERS - 1) + N_LAYERS.

Test Plan:
- Reset mid-run (stage=FP, layer 1), assert rst asynchronously -> outputs return to reset values before the next edge; stage=IDLE, busy=0.
- N_LAYERS=3, train_en=0, start; `stage_done` 1 cycle after each `stage_go` -> go sequence A0, FP0, FP1, FP2, SOFTMAX; `run_done` after 10 cycles of busy; sample_cnt=0 throughout.
- N_LAYERS=3, BATCH=2, train_en=1 -> 29 `stage_go` pulses in order: per sample A0, FP0-2, SOFTMAX, BPdZ2, BPdW2, BPdA2, BPdZ1, BPdW1, BPdA1, BPdZ0, BPdW0 with sample_cnt 0 then 1; then PU0-2; one `run_done`; no BPdA at layer 0.
- `stage_done` asserted in the go cycle and while IDLE -> ignored, no advance. `stage_done` held 3 cycles -> advances one stage per honoured cycle.
- Mid-run in BPdW, layer 2, drive abort together with `stage_done` -> IDLE next cycle, no `run_done`, no `stage_go`. A new start is accepted afterwards.
- N_LAYERS=1, BATCH=1, train_en=1 -> sequence A0, FP0, SOFTMAX, BPdZ0, BPdW0, PU0 (6 `stage_go` pulses); start pulsed during the run is ignored.
